// File: rtl/linear_interp_x8_pkg.sv
// Shared definitions for the 8x linear interpolator: FSM encoding,
// output-select encoding and default widths.
package linear_interp_x8_pkg;

    localparam int W_DEF     = 18;
    localparam int LOG2L_DEF = 3;
    localparam int NUM_LANES = 2;   // lane 0 = L+R, lane 1 = L-R

    // Control FSM: needs two input samples before a segment exists.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        RUN    = 2'd2
    } interp_state_t;

    // What a lane loads into its output register on an output strobe.
    typedef enum logic [1:0] {
        OSEL_ZERO = 2'd0,
        OSEL_CURR = 2'd1,
        OSEL_ACC  = 2'd2
    } out_sel_t;

endpackage

// File: rtl/linear_interp_x8_if.sv
// Strobe/sample bundle between the 48 kHz stage, the interpolator and
// the 384 kHz consumer.
interface linear_interp_x8_if #(
    parameter int W = linear_interp_x8_pkg::W_DEF
);
    logic                clken_in;
    logic                clken_out;
    logic signed [W-1:0] LpR_in;
    logic signed [W-1:0] LmR_in;
    logic signed [W-1:0] LpR_out;
    logic signed [W-1:0] LmR_out;
    logic                out_strobe;
    logic                starve;

    modport master (
        output clken_in, clken_out, LpR_in, LmR_in,
        input  LpR_out, LmR_out, out_strobe, starve
    );

    modport slave (
        input  clken_in, clken_out, LpR_in, LmR_in,
        output LpR_out, LmR_out, out_strobe, starve
    );
endinterface

// File: rtl/linear_interp_x8_lane.sv
// One interpolation channel: sample pair, scaled accumulator and output
// register. Sequencing decisions come from the shared control in the top.
module interp_lane
    import linear_interp_x8_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOG2L = LOG2L_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,     // take a new input sample
    input  logic                advance,  // step acc by one phase
    input  logic                out_en,   // update the output register
    input  out_sel_t            out_sel,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);
    localparam int AW = W + LOG2L + 1;

    logic signed [W-1:0]  x_prev, x_curr;
    logic signed [W:0]    delta, delta_new;
    logic signed [AW-1:0] acc, acc_base, delta_ext, delta_new_ext;

    // delta is fully determined by the held sample pair, so it is derived
    // rather than stored a second time.
    assign delta     = {x_curr[W-1], x_curr} - {x_prev[W-1], x_prev};
    // Slope of the segment being loaded this cycle (input - old x_curr).
    assign delta_new = {din[W-1], din} - {x_curr[W-1], x_curr};

    assign acc_base      = {x_curr[W-1], x_curr, {LOG2L{1'b0}}};
    assign delta_ext     = {{LOG2L{delta[W]}}, delta};
    assign delta_new_ext = {{LOG2L{delta_new[W]}}, delta_new};

    // Sample pair, accumulator and output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_prev <= '0;
            x_curr <= '0;
            acc    <= '0;
            dout   <= '0;
        end else begin
            if (load) begin
                x_prev <= x_curr;
                x_curr <= din;
                // Coincident output strobe consumes phase 0 immediately.
                acc    <= advance ? acc_base + delta_new_ext : acc_base;
            end else if (advance) begin
                acc <= acc + delta_ext;
            end

            if (out_en) begin
                case (out_sel)
                    OSEL_ZERO: dout <= '0;
                    OSEL_CURR: dout <= x_curr;
                    // acc/L always lies between the two samples, so the
                    // middle slice equals the arithmetic (floor) shift.
                    default:   dout <= acc[AW-2:LOG2L];
                endcase
            end
        end
    end

endmodule

// File: rtl/linear_interp_x8.sv
// 8x linear interpolator for the L+R / L-R pair (48 kHz -> 384 kHz).
// Shared control (FSM, phase counter, strobes, starve) lives here; the
// two channel datapaths are identical interp_lane instances.
module linear_interp_x8
    import linear_interp_x8_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOG2L = LOG2L_DEF
) (
    input  logic              clock,
    input  logic              reset,
    linear_interp_x8_if.slave bus
);
    localparam logic [LOG2L:0] K_END = (LOG2L+1)'(1 << LOG2L);

    interp_state_t  state, state_nxt;
    logic [LOG2L:0] k, k_nxt;
    logic           starve_q, starve_nxt;
    logic           out_strobe_q;
    logic           advance;
    out_sel_t       out_sel;

    logic [NUM_LANES-1:0][W-1:0] lane_din, lane_dout;

    // Control state registers; out_strobe trails clken_out by one clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            k            <= '0;
            starve_q     <= 1'b0;
            out_strobe_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            starve_q     <= starve_nxt;
            out_strobe_q <= bus.clken_out;
        end
    end

    // Next state, phase counter and lane control; a load wins over output.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        starve_nxt = starve_q;
        advance    = 1'b0;

        case (state)
            EMPTY:   out_sel = OSEL_ZERO;
            PRIMED:  out_sel = OSEL_CURR;
            RUN:     out_sel = (k == K_END) ? OSEL_CURR : OSEL_ACC;
            default: out_sel = OSEL_ZERO;
        endcase

        if (bus.clken_in) begin
            // New segment; a coincident output shows its phase 0 (old x_curr).
            out_sel = OSEL_CURR;
            advance = bus.clken_out;
            k_nxt   = {{LOG2L{1'b0}}, bus.clken_out};
            case (state)
                EMPTY:   state_nxt = PRIMED;
                PRIMED:  state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end else if (bus.clken_out && state == RUN) begin
            if (k == K_END) begin
                starve_nxt = 1'b1;   // segment exhausted, hold x_curr
            end else begin
                advance = 1'b1;
                k_nxt   = k + 1'b1;
            end
        end
    end

    assign lane_din = {bus.LmR_in, bus.LpR_in};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        interp_lane #(
            .W     (W),
            .LOG2L (LOG2L)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .load    (bus.clken_in),
            .advance (advance),
            .out_en  (bus.clken_out),
            .out_sel (out_sel),
            .din     (lane_din[i]),
            .dout    (lane_dout[i])
        );
    end

    assign bus.LpR_out    = lane_dout[0];
    assign bus.LmR_out    = lane_dout[1];
    assign bus.out_strobe = out_strobe_q;
    assign bus.starve     = starve_q;

endmodule

// File: doc/linear_interp_x8.md
LINEAR_INTERP_X8 -- requirements
Module: linear_interp_x8

Interface
REQ-001 Parameter W, 18, sample width (signed two's complement).
REQ-002 Parameter LOG2L, 3, log2 of the interpolation factor (L = 8).
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clken_in  input  1  one-cycle strobe at 48 kHz; the L+R and L-R inputs are valid when it is high.
REQ-006 clken_out  input  1  one-cycle strobe at 8x the clken_in rate (384 kHz).
REQ-007 LpR_in  input  W  signed L+R sample from the 48 kHz stage.
REQ-008 LmR_in  input  W  signed L-R sample from the 48 kHz stage.
REQ-009 LpR_out  output  W  signed interpolated L+R sample, registered.
REQ-010 LmR_out  output  W  signed interpolated L-R sample, registered.
REQ-011 out_strobe  output  1  one-cycle pulse when LpR_out and LmR_out update.
REQ-012 starve  output  1  sticky flag: more than 8 clken_out strobes occurred between two clken_in strobes.

Function
REQ-013 Each lane SHALL hold x_prev, x_curr (W bits), delta = x_curr - x_prev (W+1 bits), accumulator acc (W+LOG2L+1 bits) and a phase counter k (0..8).
REQ-014 Lanes SHALL share state, k and strobes; only the datapaths differ.
REQ-015 Control FSM states SHALL be EMPTY -> PRIMED -> RUN.
  - EMPTY -> PRIMED on the first clken_in.
  - PRIMED -> RUN on the second clken_in.
  - RUN persists until reset.
REQ-016 On clken_in, each lane SHALL update x_prev <= x_curr, x_curr <= input, acc <= old x_curr <<< LOG2L, k <= 0.
REQ-017 On clken_out in RUN with k < 8, each lane SHALL do the following:
  - output <= acc >>> LOG2L (arithmetic shift, floor);
  - acc <= acc + delta;
  - k <= k + 1.
REQ-018 The output at phase k SHALL equal x_prev + floor(k*delta/8), k = 0..7.
REQ-019 On clken_out in RUN with k = 8, output SHALL be x_curr, acc and k SHALL hold, and starve SHALL be set.
REQ-020 On clken_out in EMPTY, outputs SHALL be 0; in PRIMED, outputs SHALL be x_curr.
REQ-021 out_strobe SHALL be high exactly the cycle after every clken_out, in all states (latency 1 clock).
REQ-022 When clken_in and clken_out coincide, the load SHALL take priority and the output SHALL be the new segment's phase 0 (old x_curr).
  - In that cycle: acc <= (old x_curr <<< LOG2L) + (input - old x_curr), k <= 1.
  - The FSM transition of REQ-015 applies in the same cycle.
REQ-023 Arithmetic SHALL never overflow: |delta| <= 2^W - 1, and interpolated values lie between x_prev and x_curr, so no saturation logic is required.
REQ-024 Inputs SHALL be sampled only on clken_in; input changes at other times SHALL have no effect.

Reset
REQ-025 On reset, FSM state SHALL become EMPTY.
REQ-026 On reset, x_prev, x_curr, delta, acc, k, LpR_out, LmR_out, out_strobe and starve SHALL all become 0.
REQ-027 Reset SHALL override coincident clken_in and clken_out.
REQ-028 Reset asserted mid-segment SHALL discard the segment; the next two clken_in strobes re-prime the block.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (EMPTY, PRIMED, RUN), default W = 18, and LOG2L = 3.
REQ-030 The per-channel datapath SHALL be a sub-module interp_lane (x_prev, x_curr, delta, acc, output register) instantiated twice.
REQ-031 The FSM, k counter, out_strobe and starve SHALL live in the top module.

Verification
REQ-032 Ramp: clken_in with 0 then 800, then 8 clken_out -> outputs 0,100,200,...,700; starve = 0.
REQ-033 Negative and floor: samples 0 then -8 -> outputs 0,-1,...,-7; samples 0 then 7 -> outputs 0,0,1,2,3,4,5,6.
REQ-034 Full-scale: samples -131072 then 131071 -> phase 4 output = -1; no wrap at any phase.
REQ-035 Starvation: after priming, 9 clken_out without clken_in -> 9th output = x_curr and starve = 1; starve stays 1 after the next clken_in.
REQ-036 Coincidence: clken_in (value 1600) coincides with clken_out after segment 0->800 -> output 800 that cycle; next clken_out -> 900.
REQ-037 Reset mid-segment at phase 3 -> outputs 0 and state EMPTY; one clken_in of 50 then clken_out -> 50 (PRIMED).
